norm_to_price: RTL

NORM_TO_PRICE -- requirements
Module: bs_price

---
 rtl/norm_to_price.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/norm_to_price.sv
// Black-Scholes pricing back end: takes N(d1)/N(d2) from the norm stage and
// produces Q16.16 call/put prices, discounting the strike with a Taylor exp(-rT).
module norm_to_price #(
    parameter int WIDTH     = 32,
    parameter int EXP_TERMS = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] S,
    input  logic signed [WIDTH-1:0] K,
    input  logic signed [WIDTH-1:0] r,
    input  logic signed [WIDTH-1:0] T,
    input  logic signed [WIDTH-1:0] Nd1,
    input  logic signed [WIDTH-1:0] Nd2,
    output logic signed [WIDTH-1:0] call_price,
    output logic signed [WIDTH-1:0] put_price,
    output logic                    done,
    output logic                    busy,
    output logic                    err
);

    localparam int NW = $clog2(EXP_TERMS + 1);
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(32'sh0001_0000);
    localparam logic signed [WIDTH-1:0] TWO  = WIDTH'(32'sh0002_0000);
    localparam logic signed [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, RT, EXP, PV, PRICE} state_t;

    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p[WIDTH+15:16];
    endfunction

    function automatic logic signed [WIDTH-1:0] clamp_pos(input logic signed [WIDTH:0] d);
        if (d < 0)
            return '0;
        else if (d > (WIDTH+1)'(MAXP))
            return MAXP;
        return d[WIDTH-1:0];
    endfunction

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_s, r_k, r_r, r_t, r_nd1, r_nd2;
    logic signed [WIDTH-1:0] r_rt, r_term, r_acc, r_kd;
    logic [NW-1:0]           r_n;

    // 1/n reciprocal table; unused slots read as zero
    logic signed [WIDTH-1:0] w_inv [0:2**NW-1];
    for (genvar g = 0; g < 2**NW; g++) begin : g_inv
        assign w_inv[g] = (g >= 1 && g <= EXP_TERMS) ? WIDTH'(65536 / ((g == 0) ? 1 : g)) : '0;
    end

    logic signed [WIDTH-1:0] w_rt, w_t1, w_tn, w_sn1, w_kn2, w_kq2, w_sq1;
    logic signed [WIDTH:0]   w_call_d, w_put_d;
    logic                    w_bad;

    assign w_rt  = fx_mul(r_r, r_t);
    assign w_bad = (w_rt < 0) || (w_rt > TWO) || (r_s <= 0) || (r_k <= 0) ||
                   (r_nd1 < 0) || (r_nd1 > ONE) || (r_nd2 < 0) || (r_nd2 > ONE);

    assign w_t1  = fx_mul(r_term, -r_rt);
    assign w_tn  = fx_mul(w_t1, w_inv[r_n]);

    assign w_sn1 = fx_mul(r_s, r_nd1);
    assign w_kn2 = fx_mul(r_kd, r_nd2);
    assign w_kq2 = fx_mul(r_kd, ONE - r_nd2);
    assign w_sq1 = fx_mul(r_s, ONE - r_nd1);

    // one extra bit so the difference cannot wrap before clamping
    assign w_call_d = (WIDTH+1)'(w_sn1) - (WIDTH+1)'(w_kn2);
    assign w_put_d  = (WIDTH+1)'(w_kq2) - (WIDTH+1)'(w_sq1);

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            call_price <= '0;
            put_price  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            r_s        <= '0;
            r_k        <= '0;
            r_r        <= '0;
            r_t        <= '0;
            r_nd1      <= '0;
            r_nd2      <= '0;
            r_rt       <= '0;
            r_term     <= '0;
            r_acc      <= '0;
            r_kd       <= '0;
            r_n        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_s     <= S;
                        r_k     <= K;
                        r_r     <= r;
                        r_t     <= T;
                        r_nd1   <= Nd1;
                        r_nd2   <= Nd2;
                        err     <= 1'b0;
                        r_state <= RT;
                    end
                end
                RT: begin
                    r_rt <= w_rt;
                    if (w_bad) begin
                        call_price <= '0;
                        put_price  <= '0;
                        err        <= 1'b1;
                        done       <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_term  <= ONE;
                        r_acc   <= ONE;
                        r_n     <= NW'(1);
                        r_state <= EXP;
                    end
                end
                EXP: begin
                    r_term <= w_tn;
                    r_acc  <= r_acc + w_tn;
                    if (r_n == NW'(EXP_TERMS))
                        r_state <= PV;
                    else
                        r_n <= r_n + NW'(1);
                end
                PV: begin
                    r_kd    <= fx_mul(r_k, r_acc);
                    r_state <= PRICE;
                end
                PRICE: begin
                    call_price <= clamp_pos(w_call_d);
                    put_price  <= clamp_pos(w_put_d);
                    done       <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
